// File: rtl/sgf_normalizer.sv
// Floating-point significand normalizer: takes an add/subtract result plus exponent and
// returns a significand with the hidden bit at the MSB, using one left shift per cycle.
module sgf_normalizer #(
    parameter int W_Sgf = 23,
    parameter int W_Exp = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W_Sgf+3:0]   sgf_R,
    input  logic [W_Exp-1:0]   exp_in,
    output logic [W_Sgf+2:0]   sgf_N,
    output logic [W_Exp-1:0]   exp_out,
    output logic               busy,
    output logic               done,
    output logic               zero,
    output logic               ovf,
    output logic               unf
);

    localparam int HB = W_Sgf + 2;
    localparam logic [W_Sgf+3:0] SIG_ZERO = {(W_Sgf+4){1'b0}};
    localparam logic [W_Sgf+2:0] SGN_ZERO = {(W_Sgf+3){1'b0}};
    localparam logic [W_Exp-1:0] EXP_ZERO = {W_Exp{1'b0}};
    localparam logic [W_Exp-1:0] EXP_ONE  = {{(W_Exp-1){1'b0}}, 1'b1};
    localparam logic [W_Exp-1:0] EXP_MAX  = {W_Exp{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        SHIFT_L = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [W_Sgf+3:0]   r_sig;
    logic [W_Exp-1:0]   r_exp;
    logic [W_Sgf+2:0]   r_sgf_n;
    logic [W_Exp-1:0]   r_exp_out;
    logic               r_busy;
    logic               r_done;
    logic               r_zero;
    logic               r_ovf;
    logic               r_unf;

    logic [W_Sgf+3:0]   w_sig_rsh;
    logic [W_Sgf+3:0]   w_sig_lsh;
    logic [W_Exp-1:0]   w_exp_dec;
    logic [W_Exp-1:0]   w_exp_carry;
    logic               w_ovf;

    // Next-value candidates for the carry step and the left-shift step
    always_comb begin
        w_sig_rsh = {1'b0, r_sig[W_Sgf+3:2], r_sig[1] | r_sig[0]};
        w_sig_lsh = {r_sig[W_Sgf+2:0], 1'b0};
        w_exp_dec = r_exp - EXP_ONE;
        w_ovf     = (r_exp == EXP_MAX) || ((r_exp + EXP_ONE) == EXP_MAX);
        if (w_ovf) begin
            w_exp_carry = EXP_MAX;
        end else begin
            w_exp_carry = r_exp + EXP_ONE;
        end
    end

    // Control FSM; results and flags are only loaded on the transition into DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_sig     <= SIG_ZERO;
            r_exp     <= EXP_ZERO;
            r_sgf_n   <= SGN_ZERO;
            r_exp_out <= EXP_ZERO;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sig   <= sgf_R;
                        r_exp   <= exp_in;
                        r_zero  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    if (r_sig == SIG_ZERO) begin
                        r_exp     <= EXP_ZERO;
                        r_sgf_n   <= SGN_ZERO;
                        r_exp_out <= EXP_ZERO;
                        r_zero    <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_sig[W_Sgf+3]) begin
                        r_sig     <= w_sig_rsh;
                        r_exp     <= w_exp_carry;
                        r_sgf_n   <= w_sig_rsh[W_Sgf+2:0];
                        r_exp_out <= w_exp_carry;
                        r_ovf     <= w_ovf;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_sig[HB] || (r_exp <= EXP_ONE)) begin
                        // Already normalized, or no exponent headroom left to shift into
                        r_sgf_n   <= r_sig[W_Sgf+2:0];
                        r_exp_out <= r_exp;
                        r_unf     <= ~r_sig[HB];
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state <= SHIFT_L;
                    end
                end
                SHIFT_L: begin
                    r_sig <= w_sig_lsh;
                    r_exp <= w_exp_dec;
                    if (w_sig_lsh[HB] || (w_exp_dec == EXP_ONE)) begin
                        r_sgf_n   <= w_sig_lsh[W_Sgf+2:0];
                        r_exp_out <= w_exp_dec;
                        r_unf     <= ~w_sig_lsh[HB];
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sgf_N   = r_sgf_n;
    assign exp_out = r_exp_out;
    assign busy    = r_busy;
    assign done    = r_done;
    assign zero    = r_zero;
    assign ovf     = r_ovf;
    assign unf     = r_unf;

endmodule

// File: tb/tb_sgf_normalizer.sv
// Scoreboard bench for sgf_normalizer: expected results are queued at start and compared at done.
module tb_sgf_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [26:0] sgf_R = 27'd0;
    logic [7:0]  exp_in = 8'd0;
    logic [25:0] sgf_N;
    logic [7:0]  exp_out;
    logic        busy, done, zero, ovf, unf;

    typedef struct {
        logic [25:0] sgf;
        logic [7:0]  ex;
        logic        z;
        logic        o;
        logic        u;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [25:0] prev_sgf = 26'd0;
    logic [7:0]  prev_exp = 8'd0;

    sgf_normalizer #(.W_Sgf(23), .W_Exp(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sgf_R(sgf_R), .exp_in(exp_in),
        .sgf_N(sgf_N), .exp_out(exp_out), .busy(busy), .done(done),
        .zero(zero), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour built from the leading-one position rather than stepwise shifting
    function automatic exp_t model(input logic [26:0] r, input logic [7:0] e);
        exp_t        m;
        logic [26:0] s;
        int          p;
        int          k;
        m.sgf = 26'd0; m.ex = 8'd0; m.z = 1'b0; m.o = 1'b0; m.u = 1'b0; m.lat = 2;
        if (r == 27'd0) begin
            m.z = 1'b1;
        end else if (r[26]) begin
            s = {1'b0, r[26:2], r[1] | r[0]};
            m.sgf = s[25:0];
            if (e >= 8'd254) begin m.o = 1'b1; m.ex = 8'hFF; end
            else m.ex = e + 8'd1;
        end else if (r[25] || e <= 8'd1) begin
            m.sgf = r[25:0];
            m.ex  = e;
            m.u   = ~r[25];
        end else begin
            p = 0;
            for (int i = 0; i < 26; i++) if (r[i]) p = i;
            k = 25 - p;
            if (k > int'(e) - 1) begin k = int'(e) - 1; m.u = 1'b1; end
            s = r << k;
            m.sgf = s[25:0];
            m.ex  = e - 8'(k);
            m.lat = 2 + k;
        end
        return m;
    endfunction

    task automatic run(input logic [26:0] r, input logic [7:0] e, input exp_t x, input bit inject);
        exp_t got;
        int   c;
        @(negedge clk);
        start = 1'b1; sgf_R = r; exp_in = e;
        q.push_back(x);
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        check("busy_n1", busy, 1);
        check("flags_clr", {zero, ovf, unf}, 3'b000);
        check("hold_sgf", sgf_N, prev_sgf);
        check("hold_exp", exp_out, prev_exp);
        while (!done && c < 64) begin
            if (inject && c == 2) begin start = 1'b1; sgf_R = 27'd0; exp_in = 8'd9; end
            else start = 1'b0;
            @(posedge clk); #1;
            c++;
            check("busy_run", busy, 1);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        got = q.pop_front();
        check("latency", c, got.lat);
        check("sgf_N", sgf_N, got.sgf);
        check("exp_out", exp_out, got.ex);
        check("flags", {zero, ovf, unf}, {got.z, got.o, got.u});
        prev_sgf = got.sgf;
        prev_exp = got.ex;
        @(posedge clk); #1;
        check("done_1cyc", done, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic abort_run();
        @(negedge clk);
        start = 1'b1; sgf_R = 27'h0400000; exp_in = 8'd127;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out", {sgf_N, exp_out}, 34'd0);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_nodone", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        prev_sgf = 26'd0;
        prev_exp = 8'd0;
    endtask

    initial begin
        exp_t        x;
        logic [26:0] r;
        logic [7:0]  e;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {sgf_N, exp_out, busy, done, zero, ovf, unf}, 39'd0);
        @(negedge clk);
        rst = 1'b1;

        x = '{26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0, 2};
        run(27'h2000000, 8'd127, x, 1'b0);
        x = '{26'h2000001, 8'd128, 1'b0, 1'b0, 1'b0, 2};
        run(27'h4000003, 8'd127, x, 1'b0);
        x = '{26'h2000000, 8'd124, 1'b0, 1'b0, 1'b0, 5};
        run(27'h0400000, 8'd127, x, 1'b0);
        x = '{26'h0000000, 8'd0, 1'b1, 1'b0, 1'b0, 2};
        run(27'h0000000, 8'd77, x, 1'b0);
        x = '{26'h2000000, 8'd255, 1'b0, 1'b1, 1'b0, 2};
        run(27'h4000000, 8'd254, x, 1'b0);
        x = '{26'h2000000, 8'd255, 1'b0, 1'b1, 1'b0, 2};
        run(27'h4000000, 8'd255, x, 1'b0);
        x = '{26'h0000400, 8'd1, 1'b0, 1'b0, 1'b1, 4};
        run(27'h0000100, 8'd3, x, 1'b0);
        x = '{26'h0000100, 8'd1, 1'b0, 1'b0, 1'b1, 2};
        run(27'h0000100, 8'd1, x, 1'b0);
        x = '{26'h2000000, 8'd124, 1'b0, 1'b0, 1'b0, 5};
        run(27'h0400000, 8'd127, x, 1'b1);
        x = '{26'h2000000, 8'd102, 1'b0, 1'b0, 1'b0, 27};
        run(27'h0000001, 8'd127, x, 1'b0);

        abort_run();
        x = '{26'h2000000, 8'd124, 1'b0, 1'b0, 1'b0, 5};
        run(27'h0400000, 8'd127, x, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r = 27'($urandom) >> $urandom_range(0, 27);
            e = 8'($urandom_range(0, 255));
            run(r, e, model(r, e), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sgf_normalizer.md
SGF_NORMALIZER -- requirements
Module: sgf_normalizer

Interface
REQ-001 The block SHALL have parameter W_Sgf, default 23, fraction width (52 for double precision).
REQ-002 The block SHALL have parameter W_Exp, default 8, exponent width (11 for double precision).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a request to normalize the current sgf_R/exp_in.
REQ-006 The block SHALL have port sgf_R, input, W_Sgf+4, the add/subtract result: bit W_Sgf+3 = carry, bit W_Sgf+2 = hidden, bits 1:0 = guard/sticky.
REQ-007 The block SHALL have port exp_in, input, W_Exp, the biased exponent of the largest operand.
REQ-008 The block SHALL have port sgf_N, output, W_Sgf+3, the normalized significand (hidden bit at MSB).
REQ-009 The block SHALL have port exp_out, output, W_Exp, the adjusted exponent.
REQ-010 The block SHALL have ports busy, done, zero, ovf, unf, all outputs of width 1.

Function
REQ-011 The block SHALL use a state machine with states IDLE, EVAL, SHIFT_L and DONE; busy SHALL be high whenever the state is not IDLE.
REQ-012 start SHALL be accepted only in IDLE; an accepted start SHALL capture sgf_R and exp_in into internal registers (sig, exp) and move to EVAL.
REQ-013 start SHALL be ignored while busy is high, including in DONE.
REQ-014 EVAL SHALL go to DONE with zero=1, sig=0 and exp=0 when sig==0.
REQ-015 EVAL SHALL handle the carry case (sig[W_Sgf+3]=1) as follows:
- Shift sig right 1.
- New bit0 = old bit1 OR old bit0 (sticky).
- Set exp = exp+1.
- Go to DONE.
REQ-016 In the carry case of REQ-015, when exp+1 equals all-ones, or exp_in is already all-ones, the block SHALL set ovf=1 and saturate exp at all-ones.
REQ-017 EVAL SHALL go to DONE with no modification when sig[W_Sgf+2]=1.
REQ-018 EVAL SHALL go to SHIFT_L in all other cases.
REQ-019 In SHIFT_L, the block SHALL perform one step per cycle: shift sig left 1 with zero fill and set exp = exp-1.
REQ-020 SHIFT_L SHALL go to DONE when the post-shift sig[W_Sgf+2]=1 or the post-shift exp==1.
REQ-021 The block SHALL NOT enter SHIFT_L when exp is already <=1 in EVAL; it SHALL go to DONE with unf=1 instead.
REQ-022 The block SHALL set unf=1 when SHIFT_L terminates on exp==1 with sig[W_Sgf+2]=0.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 sgf_N SHALL equal sig[W_Sgf+2:0] and exp_out SHALL equal exp.
REQ-025 sgf_N, exp_out, zero, ovf and unf SHALL be updated only on DONE entry and held stable until the next DONE.
REQ-026 zero, ovf and unf SHALL be cleared when a start is accepted.
REQ-027 Latency SHALL be measured from start sampled at cycle N:
- Zero, carry or already-normalized input: done high at cycle N+2.
- k left shifts: done high at cycle N+2+k.
- Worst case: N+2+(W_Sgf+2).
REQ-028 The block SHALL perform no rounding; bits 1:0 SHALL pass through to the next stage.

Reset
REQ-029 rst low SHALL immediately, asynchronously:
- Force IDLE.
- Clear all outputs and internal registers to 0.
- Set busy=0 and done=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL be processed normally.

Verification
REQ-031 sgf_R=27'h2000000, exp_in=127 -> done at N+2, sgf_N=26'h2000000, exp_out=127, flags 0.
REQ-032 sgf_R=27'h4000003, exp_in=127 -> done at N+2, sgf_N=26'h2000001 (sticky set), exp_out=128.
REQ-033 sgf_R=27'h0400000, exp_in=127 -> done at N+5, sgf_N=26'h2000000, exp_out=124, busy high N+1..N+4.
REQ-034 Zero and overflow cases:
- sgf_R=0 -> done at N+2, zero=1, exp_out=0, sgf_N=0.
- sgf_R=27'h4000000, exp_in=254 -> done at N+2, ovf=1, exp_out=255, sgf_N=26'h2000000.
REQ-035 sgf_R=27'h0000100, exp_in=3 -> done at N+4, sgf_N=26'h0000400, exp_out=1, unf=1.
REQ-036 Mid-operation start and reset: start pulsed during SHIFT_L is ignored; rst low at N+3 of REQ-033 -> busy=0 and no done.
